ysyx_24100006_redirect_ctrl: RTL and testbench

- Pipeline control unit that sequences flush and redirect of the front-end pipeline registers (IF_ID, ID_EXE).
- Handles three redirect sources from the EXE stage: interrupt entry, fence.i, and taken jump/branch/mret/ecall.
- Generates the one-cycle flush pulse, the fetch redirect PC and the EXE stall.
- Runs the fence.i sequence: drain memory stages, then flush the icache, then resume fetch.

---
 rtl/ysyx_24100006_redirect_ctrl_pkg.sv | 32 +++
 rtl/ysyx_24100006_redirect_ctrl_sat_counter.sv | 29 ++
 rtl/ysyx_24100006_redirect_ctrl.sv | 158 +++++++++++++++
 tb/tb_ysyx_24100006_redirect_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100006_redirect_ctrl_pkg.sv
// Shared types for the front-end flush/redirect sequencer.
package ysyx_24100006_redirect_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF    = 32;
  localparam int unsigned DRAIN_MAX_DEF = 255;
  localparam int unsigned CNT_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDIR  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_CFLUSH = 3'd3,
    ST_RESUME = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_IRQ    = 2'd1,
    CAUSE_FENCEI = 2'd2,
    CAUSE_JMP    = 2'd3
  } cause_e;

  // Interrupt wins over fence.i, which wins over an ordinary redirect.
  function automatic cause_e decode_cause(input logic irq, input logic fence_i,
                                          input logic redirect);
    if (irq)           return CAUSE_IRQ;
    else if (fence_i)  return CAUSE_FENCEI;
    else if (redirect) return CAUSE_JMP;
    else               return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/ysyx_24100006_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when the next value sits at MAX.
module ysyx_24100006_sat_counter #(
  parameter int unsigned W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic max_hit_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (en && cnt_q != MAX)  cnt_d = cnt_q + W'(1);
  end

  assign max_hit_c = (cnt_d == MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ysyx_24100006_redirect_ctrl.sv
// Sequences pipeline flush/redirect for irq entry, taken control flow and the
// fence.i drain -> icache flush -> resume handshake.
module ysyx_24100006_redirect_ctrl
  import ysyx_24100006_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exe_fire,
  input  logic              exe_irq,
  input  logic              exe_is_fence_i,
  input  logic              exe_redirect,
  input  logic [ADDR_W-1:0] exe_target,
  input  logic [ADDR_W-1:0] exe_mtvec,
  input  logic              mem_busy,
  input  logic              icache_flush_ack,
  output logic              icache_flush_req,
  output logic              flush_o,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_hold,
  output logic              exe_stall,
  output logic              busy,
  output logic              drain_timeout
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
  logic                flush_q, flush_d;
  logic                valid_q, valid_d;
  logic                req_q, req_d;
  logic                hold_q, hold_d;
  logic                stall_q, stall_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic                cnt_hit_c;
  cause_e              cause_c;

  assign cause_c = decode_cause(exe_irq, exe_is_fence_i, exe_redirect);

  ysyx_24100006_sat_counter #(
    .W   (CNT_W),
    .MAX (CNT_W'(DRAIN_MAX))
  ) u_drain_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_q != ST_DRAIN),
    .en        (state_q == ST_DRAIN),
    .max_hit_c (cnt_hit_c)
  );

  // Next-state logic; outputs below are derived from the state being entered.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exe_fire && !flush_q) begin
          unique case (cause_c)
            CAUSE_IRQ: begin
              target_d = exe_mtvec;
              state_d  = ST_REDIR;
            end
            CAUSE_FENCEI: begin
              target_d = exe_target;
              state_d  = ST_DRAIN;
            end
            CAUSE_JMP: begin
              target_d = exe_target;
              state_d  = ST_REDIR;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_REDIR:  state_d = ST_IDLE;
      ST_DRAIN: begin
        if (!mem_busy) state_d = ST_CFLUSH;
        if (cnt_hit_c) timeout_d = 1'b1;
      end
      ST_CFLUSH: if (icache_flush_ack) state_d = ST_RESUME;
      ST_RESUME: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flush_d       = 1'b0;
    valid_d       = 1'b0;
    req_d         = 1'b0;
    hold_d        = 1'b0;
    stall_d       = 1'b0;
    redirect_pc_d = redirect_pc_q;
    busy_d        = (state_d != ST_IDLE);
    unique case (state_d)
      ST_REDIR: begin
        flush_d       = 1'b1;
        valid_d       = 1'b1;
        redirect_pc_d = target_d;
      end
      ST_DRAIN: begin
        flush_d = (state_q == ST_IDLE);
        hold_d  = 1'b1;
        stall_d = 1'b1;
      end
      ST_CFLUSH: begin
        req_d   = 1'b1;
        hold_d  = 1'b1;
        stall_d = 1'b1;
      end
      ST_RESUME: begin
        valid_d       = 1'b1;
        redirect_pc_d = target_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      valid_q       <= 1'b0;
      req_q         <= 1'b0;
      hold_q        <= 1'b0;
      stall_q       <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      valid_q       <= valid_d;
      req_q         <= req_d;
      hold_q        <= hold_d;
      stall_q       <= stall_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  assign icache_flush_req = req_q;
  assign flush_o          = flush_q;
  assign redirect_valid   = valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign fetch_hold       = hold_q;
  assign exe_stall        = stall_q;
  assign busy             = busy_q;
  assign drain_timeout    = timeout_q;

endmodule

// File: tb/tb_ysyx_24100006_redirect_ctrl.sv
// Directed bench: vector table for single-cycle redirects plus hand-written fence.i sequences.
module tb_ysyx_24100006_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exe_fire, exe_irq, exe_is_fence_i, exe_redirect;
  logic [31:0] exe_target, exe_mtvec;
  logic        mem_busy, icache_flush_ack;
  logic        icache_flush_req, flush_o, redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_hold, exe_stall, busy, drain_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_24100006_redirect_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .exe_fire         (exe_fire),
    .exe_irq          (exe_irq),
    .exe_is_fence_i   (exe_is_fence_i),
    .exe_redirect     (exe_redirect),
    .exe_target       (exe_target),
    .exe_mtvec        (exe_mtvec),
    .mem_busy         (mem_busy),
    .icache_flush_ack (icache_flush_ack),
    .icache_flush_req (icache_flush_req),
    .flush_o          (flush_o),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .fetch_hold       (fetch_hold),
    .exe_stall        (exe_stall),
    .busy             (busy),
    .drain_timeout    (drain_timeout)
  );

  typedef struct {
    logic        fire, irq, fence, redir;
    logic [31:0] target, mtvec;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exe();
    exe_fire = 0; exe_irq = 0; exe_is_fence_i = 0; exe_redirect = 0;
  endtask

  task automatic start_fence(input logic [31:0] tgt);
    exe_fire = 1; exe_is_fence_i = 1; exe_target = tgt;
    step();
    clear_exe();
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 1, 32'h8000_0100, 32'h8000_0400, 1, 32'h8000_0100};
    vecs[1] = '{1, 1, 0, 1, 32'h8000_0010, 32'h8000_0400, 1, 32'h8000_0400};
    vecs[2] = '{1, 1, 0, 0, 32'h8000_0020, 32'h8000_0800, 1, 32'h8000_0800};
    vecs[3] = '{0, 0, 0, 1, 32'h8000_0030, 32'h8000_0900, 0, 32'h0};
    vecs[4] = '{1, 0, 0, 0, 32'h8000_0040, 32'h8000_0a00, 0, 32'h0};

    reset = 1; clear_exe();
    exe_target = 0; exe_mtvec = 0; mem_busy = 0; icache_flush_ack = 0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_flush", 32'(flush_o), 0);
    check("rst_pc", redirect_pc, 0);
    check("rst_timeout", 32'(drain_timeout), 0);
    #3 reset = 0;
    step();

    // single-cycle redirects
    for (int i = 0; i < 5; i++) begin
      exe_fire = vecs[i].fire; exe_irq = vecs[i].irq;
      exe_is_fence_i = vecs[i].fence; exe_redirect = vecs[i].redir;
      exe_target = vecs[i].target; exe_mtvec = vecs[i].mtvec;
      step();
      clear_exe();
      check($sformatf("v%0d_valid", i), 32'(redirect_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_flush", i), 32'(flush_o), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("v%0d_pc", i), redirect_pc, vecs[i].exp_pc);
      step();
      check($sformatf("v%0d_idle_valid", i), 32'(redirect_valid), 0);
      check($sformatf("v%0d_idle_busy", i), 32'(busy), 0);
    end

    // fence.i with mem busy for 5 cycles, ack on the third request cycle
    mem_busy = 1;
    start_fence(32'h8000_0204);
    check("f_flush_entry", 32'(flush_o), 1);
    check("f_hold_entry", 32'(fetch_hold), 1);
    check("f_stall_entry", 32'(exe_stall), 1);
    check("f_req_entry", 32'(icache_flush_req), 0);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        exe_fire = 1; exe_redirect = 1; exe_target = 32'h8000_0f00;
      end
      if (c == 2) icache_flush_ack = 1;
      step();
      clear_exe(); icache_flush_ack = 0;
      check($sformatf("f_drain%0d_flush", c), 32'(flush_o), 0);
      check($sformatf("f_drain%0d_hold", c), 32'(fetch_hold), 1);
      check($sformatf("f_drain%0d_stall", c), 32'(exe_stall), 1);
      check($sformatf("f_drain%0d_req", c), 32'(icache_flush_req), 0);
      check($sformatf("f_drain%0d_valid", c), 32'(redirect_valid), 0);
    end
    mem_busy = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("f_req%0d", c), 32'(icache_flush_req), 1);
      check($sformatf("f_req%0d_hold", c), 32'(fetch_hold), 1);
      check($sformatf("f_req%0d_stall", c), 32'(exe_stall), 1);
    end
    icache_flush_ack = 1;
    step();
    icache_flush_ack = 0;
    check("f_resume_valid", 32'(redirect_valid), 1);
    check("f_resume_pc", redirect_pc, 32'h8000_0204);
    check("f_resume_req", 32'(icache_flush_req), 0);
    check("f_resume_hold", 32'(fetch_hold), 0);
    check("f_resume_stall", 32'(exe_stall), 0);
    check("f_resume_flush", 32'(flush_o), 0);
    step();
    check("f_idle_busy", 32'(busy), 0);
    check("f_idle_valid", 32'(redirect_valid), 0);

    // fast fence.i: redirect 3 cycles after capture
    start_fence(32'h8000_0300);
    check("ff_c1_flush", 32'(flush_o), 1);
    step();
    check("ff_c2_req", 32'(icache_flush_req), 1);
    icache_flush_ack = 1;
    step();
    icache_flush_ack = 0;
    check("ff_c3_valid", 32'(redirect_valid), 1);
    check("ff_c3_pc", redirect_pc, 32'h8000_0300);
    step();

    // drain watchdog
    mem_busy = 1;
    start_fence(32'h8000_0500);
    for (int c = 0; c < 253; c++) step();
    check("wd_before", 32'(drain_timeout), 0);
    for (int c = 0; c < 3; c++) step();
    check("wd_after", 32'(drain_timeout), 1);
    check("wd_still_drain", 32'(fetch_hold), 1);
    for (int c = 0; c < 44; c++) step();
    mem_busy = 0;
    step();
    check("wd_cflush", 32'(icache_flush_req), 1);
    icache_flush_ack = 1;
    step();
    icache_flush_ack = 0;
    check("wd_resume_pc", redirect_pc, 32'h8000_0500);
    step();
    check("wd_sticky", 32'(drain_timeout), 1);
    check("wd_idle", 32'(busy), 0);

    // async reset mid-CFLUSH, late ack ignored
    start_fence(32'h8000_0600);
    step();
    check("ar_req_before", 32'(icache_flush_req), 1);
    #2 reset = 1;
    #1;
    check("ar_req", 32'(icache_flush_req), 0);
    check("ar_hold", 32'(fetch_hold), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_timeout", 32'(drain_timeout), 0);
    #3 reset = 0;
    step();
    icache_flush_ack = 1;
    step();
    icache_flush_ack = 0;
    check("ar_late_busy", 32'(busy), 0);
    check("ar_late_valid", 32'(redirect_valid), 0);
    step();
    check("ar_late_busy2", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
